feistel_iter_core: RTL

- Parametrised, iterative Feistel engine covering both directions: encryption and decryption, chosen per block by a mode bit.
- Holds a writable round-key table.
- Drives an external round-function unit (the F datapath, with its shared S-box) through a request/response port, one round at a time, so a single F instance serves every round.
- Sits between the chaotic key generator and the image stream, with ready/valid back-pressure on both the input and output sides.

---
 rtl/feistel_iter_core.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/feistel_iter_core.sv
// Iterative Feistel engine: one external F round per request, encrypt or decrypt per block.
// Defining FEISTEL_ITER_TIMEOUT_EN builds a WAIT watchdog that drops a stalled block and pulses err.
module feistel_iter_core #(
    parameter int ROUNDS     = 5,
    parameter int DATA_WIDTH = 256,
    parameter int KEY_SIZE   = 128,
    parameter int KIDX_W     = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_we,
    input  logic [KIDX_W-1:0]       key_idx,
    input  logic [KEY_SIZE-1:0]     key_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    f_req_valid,
    output logic [DATA_WIDTH/2-1:0] f_req_state,
    output logic [KEY_SIZE-1:0]     f_req_key,
    input  logic                    f_rsp_valid,
    input  logic [DATA_WIDTH/2-1:0] f_rsp_state,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    busy,
    output logic                    err
);
    localparam int HALF = DATA_WIDTH / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (ROUNDS < 1 || (DATA_WIDTH % 2) != 0 || (2 ** KIDX_W) < ROUNDS || TIMEOUT < 1) begin : g_bad_params
        $error("feistel_iter_core: illegal parameter combination");
    end

    logic [1:0]            state_q, state_d;
    logic [HALF-1:0]       lh_q, lh_d;
    logic [HALF-1:0]       rh_q, rh_d;
    logic                  mode_q, mode_d;
    logic [KIDX_W-1:0]     rnd_q, rnd_d;
    logic [KEY_SIZE-1:0]   keys_q [ROUNDS];
    logic [KEY_SIZE-1:0]   keys_d [ROUNDS];
    logic [KIDX_W-1:0]     kidx_s;
    logic [KEY_SIZE-1:0]   req_key_s;
    logic                  last_s;
    logic                  timeout_s;

    logic                  in_ready_q;
    logic                  busy_q;
    logic                  f_req_valid_q;
    logic [HALF-1:0]       f_req_state_q;
    logic [KEY_SIZE-1:0]   f_req_key_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    // Decrypt walks the key table backwards; the index is derived from the round about to be requested.
    function automatic logic [KIDX_W-1:0] key_index(input logic [KIDX_W-1:0] rnd, input logic dec);
        logic [KIDX_W-1:0] top;
        top = KIDX_W'(ROUNDS - 1);
        return dec ? (top - rnd) : rnd;
    endfunction

    // Round-key lookup for the next request
    always_comb begin
        req_key_s = {KEY_SIZE{1'b0}};
        kidx_s    = key_index(rnd_d, mode_d);
        for (int i = 0; i < ROUNDS; i++) begin
            req_key_s = (int'(kidx_s) == i) ? keys_q[i] : req_key_s;
        end
    end

    // Key table write port, open only while idle
    always_comb begin
        for (int i = 0; i < ROUNDS; i++) begin
            keys_d[i] = (state_q == S_IDLE && key_we && int'(key_idx) == i) ? key_data : keys_q[i];
        end
    end

    assign last_s = (int'(rnd_q) == ROUNDS - 1);

    // Round sequencing FSM next-state logic
    always_comb begin
        state_d = state_q;
        lh_d    = lh_q;
        rh_d    = rh_q;
        mode_d  = mode_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    lh_d    = in_data[DATA_WIDTH-1:HALF];
                    rh_d    = in_data[HALF-1:0];
                    mode_d  = in_mode;
                    rnd_d   = {KIDX_W{1'b0}};
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (f_rsp_valid) begin
                    lh_d    = rh_q;
                    rh_d    = lh_q ^ f_rsp_state;
                    rnd_d   = rnd_q + {{(KIDX_W-1){1'b0}}, 1'b1};
                    state_d = last_s ? S_DONE : S_REQ;
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef FEISTEL_ITER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q;

    // Watchdog: restarts on every request, counts cycles spent waiting for F
    always_comb begin
        if (state_q == S_REQ) begin
            wd_d = {WD_W{1'b0}};
        end else if (state_q == S_WAIT) begin
            wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_d = wd_q;
        end
        timeout_s = (state_q == S_WAIT) && !f_rsp_valid && (wd_q == WD_W'(TIMEOUT - 1));
    end

    // Watchdog counter and one-cycle error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= {WD_W{1'b0}};
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= timeout_s;
        end
    end

    assign err = err_q;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Datapath and key table state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lh_q    <= {HALF{1'b0}};
            rh_q    <= {HALF{1'b0}};
            mode_q  <= 1'b0;
            rnd_q   <= {KIDX_W{1'b0}};
            for (int i = 0; i < ROUNDS; i++) begin
                keys_q[i] <= {KEY_SIZE{1'b0}};
            end
        end else begin
            state_q <= state_d;
            lh_q    <= lh_d;
            rh_q    <= rh_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
            for (int i = 0; i < ROUNDS; i++) begin
                keys_q[i] <= keys_d[i];
            end
        end
    end

    // Registered outputs, decoded from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            f_req_valid_q <= 1'b0;
            f_req_state_q <= {HALF{1'b0}};
            f_req_key_q   <= {KEY_SIZE{1'b0}};
            out_valid_q   <= 1'b0;
            out_data_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            in_ready_q    <= (state_d == S_IDLE);
            busy_q        <= (state_d != S_IDLE);
            f_req_valid_q <= (state_d == S_REQ);
            out_valid_q   <= (state_d == S_DONE);
            if (state_d == S_REQ) begin
                f_req_state_q <= rh_d;
                f_req_key_q   <= req_key_s;
            end
            // Final half-swap happens as the last round result is folded in
            if (state_q == S_WAIT && state_d == S_DONE) begin
                out_data_q <= {rh_d, lh_d};
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign f_req_valid = f_req_valid_q;
    assign f_req_state = f_req_state_q;
    assign f_req_key   = f_req_key_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

    feistel_iter_core_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .in_ready    (in_ready_q),
        .busy        (busy_q),
        .f_req_valid (f_req_valid_q),
        .out_valid   (out_valid_q),
        .out_ready   (out_ready),
        .out_data    (out_data_q)
    );
endmodule

// Protocol properties of the engine's own outputs.
module feistel_iter_core_chk #(
    parameter int DATA_WIDTH = 256
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  in_ready,
    input logic                  busy,
    input logic                  f_req_valid,
    input logic                  out_valid,
    input logic                  out_ready,
    input logic [DATA_WIDTH-1:0] out_data
);
    a_ready_excl_busy: assert property (@(posedge clk) disable iff (reset) in_ready != busy);
    a_ready_excl_out:  assert property (@(posedge clk) disable iff (reset) !(in_ready && out_valid));
    a_req_pulse:       assert property (@(posedge clk) disable iff (reset) f_req_valid |=> !f_req_valid);
    a_out_hold:        assert property (@(posedge clk) disable iff (reset)
                                        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
endmodule
